// File: rtl/multicyc_mem_if.sv
// Multicycle memory interface: one bus access at a time for a
// multicycle controller, with alignment and timeout fault capture.
module multicyc_mem_if #(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] IR_RESET       = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_addr_sel,
    input  logic        ir_we,
    input  logic        mem_we,
    input  logic        mdr_load,
    input  logic [31:0] pc,
    input  logic [31:0] aluout,
    input  logic [31:0] wdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ready,
    output logic [31:0] instr,
    output logic [31:0] mdr,
    output logic        stall,
    output logic        fault
);

    localparam int CLOG = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW   = (CLOG > 8) ? CLOG : 8;
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, next;
    logic [CW-1:0] wait_cnt;
    logic          fetch_q, we_q;
    logic          req;
    logic [31:0]   addr;
    logic          latch, misal, fin_ok, tmo;

    assign req  = ir_we | mem_we | mdr_load;
    assign addr = mem_addr_sel ? aluout : pc;

    always_comb begin
        next   = state;
        latch  = 1'b0;
        misal  = 1'b0;
        fin_ok = 1'b0;
        tmo    = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    if (addr[1:0] == 2'b00) begin
                        latch = 1'b1;
                        next  = BUSY;
                    end else begin
                        misal = 1'b1;
                        next  = DONE;
                    end
                end
            end
            BUSY: begin
                // a completion in the final allowed cycle beats the timeout
                if (bus_ready) begin
                    fin_ok = 1'b1;
                    next   = DONE;
                end else if (wait_cnt == TMO_LAST) begin
                    tmo  = 1'b1;
                    next = DONE;
                end
            end
            DONE:    next = IDLE;
            default: next = IDLE;
        endcase
    end

    assign bus_req = (state == BUSY);
    assign bus_we  = (state == BUSY) & we_q;
    assign stall   = ~reset &
                     (((state == IDLE) & req) | (state == BUSY));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            fetch_q   <= 1'b0;
            we_q      <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            instr     <= IR_RESET;
            mdr       <= '0;
            fault     <= 1'b0;
        end else begin
            state <= next;
            if (latch) begin
                wait_cnt  <= '0;
                fetch_q   <= ir_we;
                we_q      <= ~ir_we & mem_we;
                bus_addr  <= addr;
                bus_wdata <= wdata;
            end else if (state == BUSY && !bus_ready) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (fin_ok) begin
                if (fetch_q)
                    instr <= bus_rdata;
                else if (!we_q)
                    mdr <= bus_rdata;
            end
            if (misal | tmo)
                fault <= 1'b1;
        end
    end

endmodule

// File: tb/tb_multicyc_mem_if.sv
// Directed bench for multicyc_mem_if with hand-computed expectations.
module tb_multicyc_mem_if;

    localparam logic [31:0] IRR = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_addr_sel, ir_we, mem_we, mdr_load;
    logic [31:0] pc, aluout, wdata;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic        bus_ready;
    logic [31:0] instr, mdr;
    logic        stall, fault;

    int total = 0;
    int bad   = 0;

    multicyc_mem_if #(
        .TIMEOUT_CYCLES(4),
        .IR_RESET      (IRR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_addr_sel(mem_addr_sel),
        .ir_we       (ir_we),
        .mem_we      (mem_we),
        .mdr_load    (mdr_load),
        .pc          (pc),
        .aluout      (aluout),
        .wdata       (wdata),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_rdata   (bus_rdata),
        .bus_ready   (bus_ready),
        .instr       (instr),
        .mdr         (mdr),
        .stall       (stall),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_req();
        ir_we    = 1'b0;
        mem_we   = 1'b0;
        mdr_load = 1'b0;
    endtask

    task automatic access(input logic        sel,
                          input logic        iw,
                          input logic        mw,
                          input logic        ml,
                          input logic [31:0] exp_addr,
                          input logic [31:0] rd,
                          input int          waits,
                          input logic        exp_we);
        mem_addr_sel = sel;
        ir_we        = iw;
        mem_we       = mw;
        mdr_load     = ml;
        #1;
        chk("idle_stall", {31'b0, stall}, 1);
        tick();
        for (int i = 0; i <= waits; i++) begin
            chk("busy_req", {31'b0, bus_req}, 1);
            chk("busy_stall", {31'b0, stall}, 1);
            chk("busy_addr", bus_addr, exp_addr);
            chk("busy_we", {31'b0, bus_we}, {31'b0, exp_we});
            if (exp_we)
                chk("busy_wdata", bus_wdata, wdata);
            if (i == waits) begin
                bus_ready = 1'b1;
                bus_rdata = rd;
            end
            tick();
        end
        bus_ready = 1'b0;
        bus_rdata = 32'hBAD0_BAD0;
        chk("done_stall", {31'b0, stall}, 0);
        chk("done_req", {31'b0, bus_req}, 0);
        clr_req();
        tick();
    endtask

    initial begin
        reset        = 1'b1;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b1;
        mem_we       = 1'b0;
        mdr_load     = 1'b0;
        pc           = 32'h0;
        aluout       = 32'h0;
        wdata        = 32'h0;
        bus_rdata    = 32'hBAD0_BAD0;
        bus_ready    = 1'b0;
        tick();
        tick();
        chk("rst_instr", instr, IRR);
        chk("rst_mdr", mdr, 0);
        chk("rst_fault", {31'b0, fault}, 0);
        chk("rst_req", {31'b0, bus_req}, 0);
        chk("rst_we", {31'b0, bus_we}, 0);
        chk("rst_addr", bus_addr, 0);
        chk("rst_wdata", bus_wdata, 0);
        chk("rst_stall", {31'b0, stall}, 0);
        clr_req();
        reset = 1'b0;
        tick();

        pc = 32'h40;
        access(1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h8C22_0004, 0, 1'b0);
        chk("fetch_instr", instr, 32'h8C22_0004);

        aluout = 32'h104;
        access(1'b1, 1'b0, 1'b0, 1'b1, 32'h104, 32'hDEAD_BEEF, 3, 1'b0);
        chk("load_mdr", mdr, 32'hDEAD_BEEF);
        chk("load_instr", instr, 32'h8C22_0004);
        chk("load_nofault", {31'b0, fault}, 0);

        aluout = 32'h200;
        wdata  = 32'h1234;
        access(1'b1, 1'b0, 1'b1, 1'b0, 32'h200, 32'h5555_AAAA, 2, 1'b1);
        chk("store_instr", instr, 32'h8C22_0004);
        chk("store_mdr", mdr, 32'hDEAD_BEEF);

        pc     = 32'h44;
        aluout = 32'h208;
        access(1'b0, 1'b1, 1'b1, 1'b0, 32'h44, 32'h1111_2222, 0, 1'b0);
        chk("prio_instr", instr, 32'h1111_2222);
        chk("prio_mdr", mdr, 32'hDEAD_BEEF);

        mem_addr_sel = 1'b1;
        aluout       = 32'h102;
        mdr_load     = 1'b1;
        #1;
        chk("mis_stall", {31'b0, stall}, 1);
        chk("mis_req0", {31'b0, bus_req}, 0);
        tick();
        chk("mis_fault", {31'b0, fault}, 1);
        chk("mis_req1", {31'b0, bus_req}, 0);
        chk("mis_done", {31'b0, stall}, 0);
        chk("mis_mdr", mdr, 32'hDEAD_BEEF);
        clr_req();
        tick();
        pc = 32'h48;
        access(1'b0, 1'b1, 1'b0, 1'b0, 32'h48, 32'h0000_0042, 0, 1'b0);
        chk("mis_fetch", instr, 32'h0000_0042);
        chk("mis_sticky", {31'b0, fault}, 1);

        pc           = 32'h80;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b1;
        tick();
        tick();
        chk("rb_req", {31'b0, bus_req}, 1);
        reset     = 1'b1;
        bus_ready = 1'b1;
        bus_rdata = 32'h7777_7777;
        #1;
        chk("rb_stall", {31'b0, stall}, 0);
        tick();
        bus_ready = 1'b0;
        chk("rb_req0", {31'b0, bus_req}, 0);
        chk("rb_instr", instr, IRR);
        chk("rb_fault", {31'b0, fault}, 0);
        reset = 1'b0;
        #1;
        chk("rb_idle", {31'b0, stall}, 1);
        clr_req();
        tick();

        pc        = 32'h300;
        ir_we     = 1'b1;
        bus_rdata = 32'h9999_9999;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("tmo_req", {31'b0, bus_req}, 1);
            chk("tmo_nofault", {31'b0, fault}, 0);
            tick();
        end
        chk("tmo_fault", {31'b0, fault}, 1);
        chk("tmo_done", {31'b0, stall}, 0);
        chk("tmo_req0", {31'b0, bus_req}, 0);
        chk("tmo_instr", instr, IRR);
        clr_req();
        tick();
        chk("tmo_sticky", {31'b0, fault}, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicyc_mem_if.md
MULTICYC_MEM_IF -- requirements
Module: multicyc_mem_if

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum BUSY cycles before an access aborts.
REQ-002 Parameter IR_RESET, default 32'h0000_0000: reset value of instr.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 mem_addr_sel  in  1  address select from the controller: 0 = pc, 1 = aluout.
REQ-006 ir_we  in  1  fetch request; the read result loads instr.
REQ-007 mem_we  in  1  data write request.
REQ-008 mdr_load  in  1  data read request; the read result loads mdr.
REQ-009 pc  in  32  current program counter.
REQ-010 aluout  in  32  registered ALU result (data address).
REQ-011 wdata  in  32  store data (Rt value).
REQ-012 bus_req / bus_we  out  1 / 1  bus request and bus write strobe.
REQ-013 bus_addr / bus_wdata  out  32 / 32  bus address and bus write data.
REQ-014 bus_rdata / bus_ready  in  32 / 1  bus read data and bus completion strobe.
REQ-015 instr / mdr  out  32 / 32  instruction register and memory data register.
REQ-016 stall  out  1  freezes controller state and PC write enable while high.
REQ-017 fault  out  1  sticky alignment or timeout error flag.

Function
REQ-018 The block SHALL implement FSM states IDLE, BUSY and DONE.
REQ-019 An access is requested when ir_we | mem_we | mdr_load is high.
REQ-020 Request priority SHALL be ir_we > mem_we > mdr_load; only the highest-priority request is serviced.
REQ-021 In IDLE with a request and address[1:0]==0, the block SHALL latch address, kind and wdata, and enter BUSY at the next edge.
REQ-022 The address is aluout when mem_addr_sel=1, else pc.
REQ-023 In IDLE with a request and address[1:0]!=0, the block SHALL set fault, issue no bus request, and enter DONE.
REQ-024 stall SHALL be combinational: 1 in IDLE while a request is present, 1 in BUSY, 0 in DONE.
REQ-025 bus_req SHALL be 1 exactly while in BUSY.
REQ-026 bus_addr, bus_we and bus_wdata SHALL be driven from the latched values and held stable throughout BUSY.
REQ-027 bus_we SHALL be 1 only for a write access.
REQ-028 In BUSY with bus_ready=1, a fetch SHALL load instr from bus_rdata and a data read SHALL load mdr; the FSM then enters DONE.
REQ-029 A write access in BUSY with bus_ready=1 SHALL load neither instr nor mdr; the FSM then enters DONE.
REQ-030 An 8-bit-minimum wait counter SHALL clear on BUSY entry and increment each BUSY cycle without bus_ready.
REQ-031 When the wait counter reaches TIMEOUT_CYCLES, the block SHALL set fault, enter DONE, and update neither instr nor mdr.
REQ-032 If bus_ready arrives in the same cycle the wait counter reaches TIMEOUT_CYCLES, bus_ready SHALL win and no fault is set.
REQ-033 DONE SHALL last exactly one cycle with stall=0, ignore all requests, and return to IDLE; the controller advances on this edge.
REQ-034 Minimum latency SHALL be 3 cycles from request to stall=0 (IDLE, BUSY with bus_ready, DONE).
REQ-035 Once set, fault SHALL remain 1 until reset; later accesses still proceed normally.
REQ-036 instr and mdr SHALL hold their values except on the loads in REQ-028.

Reset
REQ-037 On reset the block SHALL set state=IDLE, instr=IR_RESET, mdr=0, fault=0, wait counter=0, bus_req=0, bus_we=0, bus_addr=0, and bus_wdata=0.
REQ-038 Reset during BUSY SHALL abandon the transaction: bus_req=0 after the reset edge, no register load, no fault.
REQ-039 While reset is high, stall SHALL be 0.

Verification
REQ-040 Fetch: pc=0x40, ir_we=1, bus_ready on the 1st BUSY cycle with rdata=0x8C220004 -> stall high for 2 cycles, bus_addr=0x40, instr=0x8C220004, stall=0 in DONE.
REQ-041 Load with wait: mdr_load=1, mem_addr_sel=1, aluout=0x104, bus_ready after 3 BUSY cycles with rdata=0xDEADBEEF -> mdr=0xDEADBEEF, instr unchanged, bus_we=0.
REQ-042 Store: mem_we=1, aluout=0x200, wdata=0x1234 -> bus_we=1, bus_wdata=0x1234 stable until bus_ready, instr and mdr unchanged.
REQ-043 Misaligned: mem_addr_sel=1, aluout=0x102 -> no bus_req, fault=1 sticky, one DONE cycle, then normal fetch succeeds with fault still 1.
REQ-044 Timeout and priority: TIMEOUT_CYCLES=4 with bus_ready held 0 -> fault=1, exit after 4 BUSY cycles; ir_we and mem_we both high -> bus_we=0 and fetch serviced.
REQ-045 Reset mid-BUSY: assert reset on the 2nd BUSY cycle -> bus_req=0 and state IDLE after the edge, instr=IR_RESET, fault=0.
